// File: rtl/bira_latency_monitor.sv
// bira_latency_monitor
//
// Watches NUM_CH BIRA repair sessions in parallel and measures, per channel,
// the cycles from end-of-test to repair completion (or early termination /
// timeout). Each finished session becomes one record that a round-robin
// arbiter moves into a show-ahead FIFO read through a valid/ready port.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   test         per-channel test-active level
//   test_end     per-channel end-of-test marker (rising edge)
//   early_term   per-channel early termination (rising edge)
//   repair       per-channel repair-busy level (falling edge)
//   solution     per-channel solution words, channel c at [c*SOL_W +: SOL_W]
//   busy         channel FSM not idle
//   rec_valid    FIFO holds at least one record
//   rec_ready    consumer takes the head record this cycle
//   rec_ch       head record channel
//   rec_code     head record code: 0 repaired, 1 early, 2 timeout
//   rec_cycles   head record latency in cycles
//   rec_solution head record solution word
//   drop_cnt     sessions lost while a channel still held its record (saturating)
module bira_latency_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 20,
  parameter int SOL_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       test,
  input  logic [NUM_CH-1:0]       test_end,
  input  logic [NUM_CH-1:0]       early_term,
  input  logic [NUM_CH-1:0]       repair,
  input  logic [NUM_CH*SOL_W-1:0] solution,
  output logic [NUM_CH-1:0]       busy,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [CH_W-1:0]         rec_ch,
  output logic [1:0]              rec_code,
  output logic [CNT_W-1:0]        rec_cycles,
  output logic [SOL_W-1:0]        rec_solution,
  output logic [7:0]              drop_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COUNT, S_PEND} ch_state_e;
  typedef enum logic [1:0] {
    CODE_REPAIRED = 2'd0,
    CODE_EARLY    = 2'd1,
    CODE_TIMEOUT  = 2'd2
  } rec_code_e;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [1:0]       code;
    logic [CNT_W-1:0] cycles;
    logic [SOL_W-1:0] sol;
  } rec_t;

  // ---------------------------------------------------------------- edges
  logic [NUM_CH-1:0] test_prev_q, end_prev_q, early_prev_q, repair_prev_q;
  logic [NUM_CH-1:0] test_rise, end_rise, early_rise, repair_fall;

  assign test_rise   = test & ~test_prev_q;
  assign end_rise    = test_end & ~end_prev_q;
  assign early_rise  = early_term & ~early_prev_q;
  assign repair_fall = ~repair & repair_prev_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      test_prev_q   <= '0;
      end_prev_q    <= '0;
      early_prev_q  <= '0;
      repair_prev_q <= '0;
    end else begin
      test_prev_q   <= test;
      end_prev_q    <= test_end;
      early_prev_q  <= early_term;
      repair_prev_q <= repair;
    end
  end

  // ------------------------------------------------------------- channels
  logic [NUM_CH-1:0] pend, drop_hit, grant_oh;
  logic [1:0]        ch_code   [NUM_CH];
  logic [CNT_W-1:0]  ch_cycles [NUM_CH];
  logic [SOL_W-1:0]  ch_sol    [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [1:0]       code_q, code_d;
    logic [SOL_W-1:0] sol_q, sol_d, sol_in;

    assign cnt_inc = cnt_q + 1'b1;
    assign sol_in  = solution[g*SOL_W +: SOL_W];

    // NOTE: every variable gets its hold value before the case statement, so
    // no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cycles_d = cycles_q;
      code_d   = code_q;
      sol_d    = sol_q;
      case (state_q)
        S_IDLE: begin
          if (test_rise[g]) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (early_rise[g]) begin
            state_d  = S_PEND;
            code_d   = CODE_EARLY;
            cycles_d = '0;
            sol_d    = sol_in;
          end else if (end_rise[g]) begin
            state_d = S_COUNT;
            cnt_d   = '0;
          end else if (!test[g]) begin
            state_d = S_IDLE;
          end
        end
        S_COUNT: begin
          // Latency reported includes the cycle the terminating event is seen.
          cnt_d = cnt_inc;
          if (early_rise[g]) begin
            state_d  = S_PEND;
            code_d   = CODE_EARLY;
            cycles_d = cnt_inc;
            sol_d    = sol_in;
          end else if (repair_fall[g]) begin
            state_d  = S_PEND;
            code_d   = CODE_REPAIRED;
            cycles_d = cnt_inc;
            sol_d    = sol_in;
          end else if (cnt_q == CNT_LAST) begin
            state_d  = S_PEND;
            code_d   = CODE_TIMEOUT;
            cycles_d = CNT_MAX;
            sol_d    = sol_in;
          end
        end
        S_PEND: begin
          if (grant_oh[g]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        cycles_q <= '0;
        code_q   <= CODE_REPAIRED;
        sol_q    <= '0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        cycles_q <= cycles_d;
        code_q   <= code_d;
        sol_q    <= sol_d;
      end
    end

    assign busy[g]      = (state_q != S_IDLE);
    assign pend[g]      = (state_q == S_PEND);
    // A new session that starts while the old record is still waiting is lost.
    assign drop_hit[g]  = (state_q == S_PEND) && test_rise[g];
    assign ch_code[g]   = code_q;
    assign ch_cycles[g] = cycles_q;
    assign ch_sol[g]    = sol_q;
  end

  // --------------------------------------------------------------- arbiter
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   grant_ch, cand;
  logic [CH_W:0]     sum;
  logic              grant_vld, push_ok, push, pop;
  logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  assign pop     = (fifo_cnt_q != '0) && rec_ready;
  assign push_ok = (fifo_cnt_q < FCNT_W'(FIFO_DEPTH)) || pop;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      cand = sum[CH_W-1:0];
      if (!grant_vld && push_ok && pend[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  assign push     = grant_vld;
  assign grant_oh = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else if (grant_vld) begin
      rr_ptr_q <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
    end
  end

  // ------------------------------------------------------------------ FIFO
  rec_t             push_rec, head_q, head_d;
  rec_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  assign push_rec = '{ch:     grant_ch,
                      code:   ch_code[grant_ch],
                      cycles: ch_cycles[grant_ch],
                      sol:    ch_sol[grant_ch]};

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    head_d     = head_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    // The head register holds its last value when the FIFO runs empty; the
    // entry written this cycle becomes the head directly when nothing is ahead.
    if (fifo_cnt_d != '0) begin
      head_d = (push && (rd_ptr_d == wr_ptr_q)) ? push_rec : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      head_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      head_q     <= head_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  // ------------------------------------------------------------ drop count
  logic [7:0] drop_cnt_q;
  logic [8:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + 9'($countones(drop_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // --------------------------------------------------------------- outputs
  assign rec_valid    = (fifo_cnt_q != '0);
  assign rec_ch       = head_q.ch;
  assign rec_code     = head_q.code;
  assign rec_cycles   = head_q.cycles;
  assign rec_solution = head_q.sol;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/bira_latency_monitor.md
# bira_latency_monitor

Synthesizable, parametrised multi-channel monitor for BIRA repair sessions: per channel it tracks test start, test end, early termination and repair completion, measures repair latency in clock cycles, and captures the repair solution word. Completed session records from all channels are merged by a round-robin arbiter into a show-ahead FIFO with a valid/ready read port. It sits beside one or more BIRA top instances and replaces bench-side latency bookkeeping with on-chip, silicon-observable measurement.

## Interface
- NUM_CH, 4: number of monitored BIRA channels (1..16)
- CNT_W, 20: latency counter width; saturation value 2^CNT_W-1
- SOL_W, 16: solution word width per channel
- FIFO_DEPTH, 8: record FIFO entries; power of two, >= 2
- CH_W, derived $clog2(NUM_CH) (min 1): channel-index width
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- test  in  NUM_CH  per-channel test-active level
- test_end  in  NUM_CH  per-channel end-of-test marker (rising edge used)
- early_term  in  NUM_CH  per-channel early termination (rising edge used)
- repair  in  NUM_CH  per-channel repair-busy level (falling edge used)
- solution  in  NUM_CH*SOL_W  channel c at bits [c*SOL_W +: SOL_W]
- busy  out  NUM_CH  channel FSM not in IDLE
- rec_valid  out  1  FIFO non-empty
- rec_ready  in  1  consumer accepts head record
- rec_ch  out  CH_W  head record channel index
- rec_code  out  2  0 REPAIRED, 1 EARLY, 2 TIMEOUT
- rec_cycles  out  CNT_W  head record latency
- rec_solution  out  SOL_W  head record solution
- drop_cnt  out  8  sessions lost while channel held a pending record, saturating

## Operation
- All inputs synchronous to clk. Edge detect per channel against a registered previous value (prev regs reset to 0).
- Per-channel FSM, states IDLE, ARMED, COUNT, PEND:
  - IDLE: test rising -> ARMED.
  - ARMED: early_term rising -> PEND, code EARLY, cycles 0; else test_end rising -> COUNT, cnt<=0; else test low -> IDLE, no record.
  - COUNT: cnt increments by 1 each cycle. Priority per cycle: early_term rising -> PEND EARLY, cycles=cnt; else repair falling -> PEND REPAIRED, cycles=cnt, solution captured from input this cycle; else cnt==2^CNT_W-2 -> PEND TIMEOUT, cycles=2^CNT_W-1. test level ignored in COUNT.
  - PEND: holds one record; on arbiter grant -> IDLE. test rising while in PEND -> drop_cnt+1 (saturate 255); record not overwritten.
  - EARLY/TIMEOUT records carry solution sampled on the transition cycle.
- Arbiter: among PEND channels, grant one per cycle, round-robin starting at rr_ptr; after grant rr_ptr <= granted+1 mod NUM_CH. Grant only if push permitted.
- FIFO: push permitted when count<FIFO_DEPTH or a pop occurs same cycle. Pop when rec_valid&&rec_ready. Pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1. Full FIFO backpressures channels (held in PEND), never drops records.
- rec_* show the head entry; undefined-free: hold last head content (0 after reset) when empty.

## Timing
- Reset: all FSMs IDLE, cnt 0, rr_ptr 0, FIFO empty, busy 0, rec_valid 0, rec_ch/rec_code/rec_cycles/rec_solution 0, drop_cnt 0.
- test_end rising sampled at edge E -> cnt=0 after E; repair falling sampled at edge E+k -> cycles=k.
- Event sampled at edge N -> PEND after N -> push at N+1 (if granted, FIFO space) -> rec_valid 1 after N+1.
- Pop at edge P -> next head visible after P; simultaneous push/pop when full keeps count full.
- Reset mid-session: all records and counters cleared immediately, no partial record emitted.

## Test plan
- Ch0: test rise, test_end rise at t, repair falls 37 cycles later, rec_ready=1 -> one record ch0, REPAIRED, cycles 37, solution 0xA5C3, rec_valid 2 cycles after repair fall.
- Ch1: test rise, early_term rise in ARMED -> record EARLY, cycles 0; early_term 10 cycles after test_end -> EARLY, cycles 10.
- CNT_W=6: repair never falls -> TIMEOUT record, cycles 63, exactly 63 cycles after test_end.
- All 4 channels repair-fall same cycle, rr_ptr 0 -> records in order ch0,1,2,3, one push per cycle; next collision starts at ch0 again (rr_ptr wrapped to 0).
- rec_ready=0, 10 sessions on NUM_CH=4, FIFO_DEPTH=8 -> 8 entries, 2 channels held in PEND, their new test rises increment drop_cnt; releasing rec_ready drains all 10 in order, none lost.
- Assert rst low while ch2 in COUNT and FIFO holds 3 records -> busy 0, rec_valid 0, drop_cnt 0 immediately; after release no stale record appears.
